audio_i2s_frame_sched: RTL and testbench

Generates the I2S bit clock and word clock from the master audio clock and schedules delivery of stereo samples from the synth engine into the I2S serializer. Buffers up to two stereo frames behind a valid/ready handshake and presents a frame-stable left/right pair to the serializer. Issues a per-frame sample request to the engine and counts underruns. Sits between the synth engine output stage and `audio_i2s_driver`: it drives that driver's sample inputs, `iAUD_BCK` and `iAUD_LRCK`.

---
 rtl/audio_i2s_frame_sched.sv | 123 ++++++++++++
 tb/tb_audio_i2s_frame_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_frame_sched.sv
// I2S bit/word clock generator and frame scheduler: buffers up to two stereo
// frames and hands a frame-stable L/R pair to the serializer at each frame boundary.
module audio_i2s_frame_sched #(
    parameter int DW          = 16,
    parameter int BCK_DIV     = 4,
    parameter int BITS_PER_CH = 32
) (
    input  logic          mCLK,
    input  logic          iRST_N,
    input  logic          iENABLE,
    input  logic          iSAMPLE_VALID,
    input  logic [DW-1:0] iLSAMPLE,
    input  logic [DW-1:0] iRSAMPLE,
    output logic          oSAMPLE_READY,
    output logic          oSAMPLE_REQ,
    output logic          oAUD_BCK,
    output logic          oAUD_LRCK,
    output logic [DW-1:0] oLSOUND,
    output logic [DW-1:0] oRSOUND,
    output logic [1:0]    oFIFO_LEVEL,
    output logic [7:0]    oUNDERRUN_CNT
);

    localparam int DIV_W = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * BITS_PER_CH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * BITS_PER_CH - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(BITS_PER_CH);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic              r_bck;
    logic              r_lrck;
    logic              r_req;
    logic [DW-1:0]     r_lsound;
    logic [DW-1:0]     r_rsound;
    logic [1:0]        r_level;
    logic [7:0]        r_underrun;
    logic [2*DW-1:0]   r_fifo [2];

    logic              w_div_wrap;
    logic              w_fall_tick;
    logic              w_boundary;
    logic              w_push;
    logic              w_pop;
    logic [DIV_W-1:0]  w_div_next;
    logic [BIT_W-1:0]  w_bit_next;

    assign w_div_wrap  = (r_div_cnt == DIV_LAST);
    assign w_div_next  = w_div_wrap ? '0 : r_div_cnt + DIV_W'(1);
    assign w_fall_tick = iENABLE && w_div_wrap && r_bck;
    assign w_bit_next  = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + BIT_W'(1);
    assign w_boundary  = w_fall_tick && (r_bit_cnt == BIT_LAST);
    // READY depends on the registered level only, so upstream sees no comb path from VALID.
    assign w_push      = iSAMPLE_VALID && (r_level < 2'd2);
    assign w_pop       = w_boundary && (r_level != 2'd0);

    always_ff @(posedge mCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_div_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_bck      <= 1'b0;
            r_lrck     <= 1'b0;
            r_req      <= 1'b0;
            r_lsound   <= '0;
            r_rsound   <= '0;
            r_level    <= 2'd0;
            r_underrun <= 8'd0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
        end else begin
            if (!iENABLE) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_bck     <= 1'b0;
                r_lrck    <= 1'b0;
            end else begin
                r_div_cnt <= w_div_next;
                if (w_div_wrap)
                    r_bck <= ~r_bck;
                if (w_fall_tick) begin
                    r_bit_cnt <= w_bit_next;
                    r_lrck    <= (w_bit_next >= BIT_HALF);
                end
            end

            r_req <= w_boundary;

            // A push landing in the boundary cycle never bypasses the FIFO.
            if (w_boundary) begin
                if (r_level != 2'd0) begin
                    r_lsound <= r_fifo[0][2*DW-1:DW];
                    r_rsound <= r_fifo[0][DW-1:0];
                end else begin
                    r_lsound <= '0;
                    r_rsound <= '0;
                    if (r_underrun != 8'hFF)
                        r_underrun <= r_underrun + 8'd1;
                end
            end

            if (w_pop && w_push) begin
                r_fifo[0] <= {iLSAMPLE, iRSAMPLE};
            end else if (w_pop) begin
                r_fifo[0] <= r_fifo[1];
                r_level   <= r_level - 2'd1;
            end else if (w_push) begin
                r_fifo[r_level[0]] <= {iLSAMPLE, iRSAMPLE};
                r_level            <= r_level + 2'd1;
            end
        end
    end

    assign oSAMPLE_READY = (r_level < 2'd2);
    assign oSAMPLE_REQ   = r_req;
    assign oAUD_BCK      = r_bck;
    assign oAUD_LRCK     = r_lrck;
    assign oLSOUND       = r_lsound;
    assign oRSOUND       = r_rsound;
    assign oFIFO_LEVEL   = r_level;
    assign oUNDERRUN_CNT = r_underrun;

endmodule

// File: tb/tb_audio_i2s_frame_sched.sv
// Directed bench for audio_i2s_frame_sched: default instance for timing/flow,
// a fast-frame instance (BCK_DIV=1, BITS_PER_CH=16) for underrun saturation.
module tb_audio_i2s_frame_sched;

    logic        mCLK = 1'b0;
    logic        iRST_N;
    logic        iENABLE;
    logic        iSAMPLE_VALID;
    logic [15:0] iLSAMPLE;
    logic [15:0] iRSAMPLE;
    logic        oSAMPLE_READY, oSAMPLE_REQ, oAUD_BCK, oAUD_LRCK;
    logic [15:0] oLSOUND, oRSOUND;
    logic [1:0]  oFIFO_LEVEL;
    logic [7:0]  oUNDERRUN_CNT;

    logic        f_rst_n;
    logic        f_ready, f_req, f_bck, f_lrck;
    logic [15:0] f_lsound, f_rsound;
    logic [1:0]  f_level;
    logic [7:0]  f_und;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 mCLK = ~mCLK;

    audio_i2s_frame_sched #(.DW(16), .BCK_DIV(4), .BITS_PER_CH(32)) u_dut (
        .mCLK(mCLK), .iRST_N(iRST_N), .iENABLE(iENABLE),
        .iSAMPLE_VALID(iSAMPLE_VALID), .iLSAMPLE(iLSAMPLE), .iRSAMPLE(iRSAMPLE),
        .oSAMPLE_READY(oSAMPLE_READY), .oSAMPLE_REQ(oSAMPLE_REQ),
        .oAUD_BCK(oAUD_BCK), .oAUD_LRCK(oAUD_LRCK),
        .oLSOUND(oLSOUND), .oRSOUND(oRSOUND),
        .oFIFO_LEVEL(oFIFO_LEVEL), .oUNDERRUN_CNT(oUNDERRUN_CNT)
    );

    audio_i2s_frame_sched #(.DW(16), .BCK_DIV(1), .BITS_PER_CH(16)) u_fast (
        .mCLK(mCLK), .iRST_N(f_rst_n), .iENABLE(1'b1),
        .iSAMPLE_VALID(1'b0), .iLSAMPLE(16'h0000), .iRSAMPLE(16'h0000),
        .oSAMPLE_READY(f_ready), .oSAMPLE_REQ(f_req),
        .oAUD_BCK(f_bck), .oAUD_LRCK(f_lrck),
        .oLSOUND(f_lsound), .oRSOUND(f_rsound),
        .oFIFO_LEVEL(f_level), .oUNDERRUN_CNT(f_und)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge; cyc = rising edges since release.
    task automatic adv(input int n);
        repeat (n) @(negedge mCLK);
        cyc += n;
    endtask

    task automatic go_to(input int c);
        if (c > cyc) adv(c - cyc);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        iSAMPLE_VALID = 1'b1;
        iLSAMPLE      = l;
        iRSAMPLE      = r;
        adv(1);
        iSAMPLE_VALID = 1'b0;
    endtask

    task automatic restart_main();
        #2 iRST_N = 1'b0;
        @(negedge mCLK);
        iRST_N = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        int n_req, n_bck, n_lrck;
        iRST_N        = 1'b0;
        f_rst_n       = 1'b0;
        iENABLE       = 1'b1;
        iSAMPLE_VALID = 1'b0;
        iLSAMPLE      = 16'h0;
        iRSAMPLE      = 16'h0;

        // Reset defaults, then timing origin with an empty FIFO
        @(negedge mCLK);
        check("rst_bck",   32'(oAUD_BCK), 32'd0);
        check("rst_lrck",  32'(oAUD_LRCK), 32'd0);
        check("rst_req",   32'(oSAMPLE_REQ), 32'd0);
        check("rst_ready", 32'(oSAMPLE_READY), 32'd1);
        check("rst_level", 32'(oFIFO_LEVEL), 32'd0);
        check("rst_und",   32'(oUNDERRUN_CNT), 32'd0);
        check("rst_lsnd",  32'(oLSOUND), 32'd0);
        iRST_N = 1'b1;
        cyc    = 0;
        go_to(3);    check("bck_c3", 32'(oAUD_BCK), 32'd0);
        go_to(4);    check("bck_c4", 32'(oAUD_BCK), 32'd1);
        go_to(8);    check("bck_c8", 32'(oAUD_BCK), 32'd0);
        go_to(12);   check("bck_c12", 32'(oAUD_BCK), 32'd1);
        go_to(255);  check("lrck_c255", 32'(oAUD_LRCK), 32'd0);
        go_to(256);  check("lrck_c256", 32'(oAUD_LRCK), 32'd1);
        go_to(511);  check("req_c511", 32'(oSAMPLE_REQ), 32'd0);
                     check("lrck_c511", 32'(oAUD_LRCK), 32'd1);
        go_to(512);  check("req_c512", 32'(oSAMPLE_REQ), 32'd1);
                     check("lrck_c512", 32'(oAUD_LRCK), 32'd0);
                     check("und_c512", 32'(oUNDERRUN_CNT), 32'd1);
                     check("lsnd_mute", 32'(oLSOUND), 32'd0);
                     check("rsnd_mute", 32'(oRSOUND), 32'd0);
        go_to(513);  check("req_c513", 32'(oSAMPLE_REQ), 32'd0);
        go_to(1024); check("req_c1024", 32'(oSAMPLE_REQ), 32'd1);
                     check("und_c1024", 32'(oUNDERRUN_CNT), 32'd2);

        // Asynchronous reset mid-cycle clears state before the next edge
        #2 iRST_N = 1'b0;
        #1;
        check("arst_req", 32'(oSAMPLE_REQ), 32'd0);
        check("arst_und", 32'(oUNDERRUN_CNT), 32'd0);
        @(negedge mCLK);
        iRST_N = 1'b1;
        cyc    = 0;

        // Normal flow: two frames queued ahead of the first boundary
        go_to(10);
        push(16'h1234, 16'hABCD);
        check("lvl_after1", 32'(oFIFO_LEVEL), 32'd1);
        check("rdy_after1", 32'(oSAMPLE_READY), 32'd1);
        push(16'h0001, 16'hFFFF);
        check("lvl_after2", 32'(oFIFO_LEVEL), 32'd2);
        check("rdy_after2", 32'(oSAMPLE_READY), 32'd0);
        go_to(511);  check("lsnd_c511", 32'(oLSOUND), 32'd0);
        go_to(512);  check("lsnd_c512", 32'(oLSOUND), 32'h1234);
                     check("rsnd_c512", 32'(oRSOUND), 32'hABCD);
                     check("req_n512", 32'(oSAMPLE_REQ), 32'd1);
                     check("lvl_c512", 32'(oFIFO_LEVEL), 32'd1);
        go_to(1024); check("lsnd_c1024", 32'(oLSOUND), 32'h0001);
                     check("rsnd_c1024", 32'(oRSOUND), 32'hFFFF);
                     check("lvl_c1024", 32'(oFIFO_LEVEL), 32'd0);
                     check("und_flow", 32'(oUNDERRUN_CNT), 32'd0);

        // Push and pop in the same boundary cycle at level 1
        go_to(1030);
        push(16'h5555, 16'h6666);
        go_to(1535); check("lvl_c1535", 32'(oFIFO_LEVEL), 32'd1);
        push(16'h7777, 16'h8888);
        check("pp_lsnd", 32'(oLSOUND), 32'h5555);
        check("pp_rsnd", 32'(oRSOUND), 32'h6666);
        check("pp_lvl", 32'(oFIFO_LEVEL), 32'd1);
        go_to(2048); check("pp_lsnd2", 32'(oLSOUND), 32'h7777);
                     check("pp_rsnd2", 32'(oRSOUND), 32'h8888);
                     check("pp_lvl2", 32'(oFIFO_LEVEL), 32'd0);
                     check("pp_und", 32'(oUNDERRUN_CNT), 32'd0);

        // Push into an empty FIFO exactly in the boundary cycle: no bypass
        go_to(2559);
        push(16'h9999, 16'hAAAA);
        check("ep_lsnd", 32'(oLSOUND), 32'd0);
        check("ep_rsnd", 32'(oRSOUND), 32'd0);
        check("ep_und", 32'(oUNDERRUN_CNT), 32'd1);
        check("ep_lvl", 32'(oFIFO_LEVEL), 32'd1);
        go_to(3072); check("ep_lsnd2", 32'(oLSOUND), 32'h9999);
                     check("ep_rsnd2", 32'(oRSOUND), 32'hAAAA);
                     check("ep_und2", 32'(oUNDERRUN_CNT), 32'd1);

        // Enable dropped mid-frame, then restarted from the timing origin
        restart_main();
        go_to(5);
        push(16'h1111, 16'h2222);
        go_to(512);  check("en_lsnd512", 32'(oLSOUND), 32'h1111);
        go_to(520);
        push(16'h3333, 16'h4444);
        go_to(800);  check("en_lrck800", 32'(oAUD_LRCK), 32'd1);
        iENABLE = 1'b0;
        adv(1);
        check("dis_bck", 32'(oAUD_BCK), 32'd0);
        check("dis_lrck", 32'(oAUD_LRCK), 32'd0);
        n_req = 0; n_bck = 0; n_lrck = 0;
        for (int i = 0; i < 399; i++) begin
            adv(1);
            if (oSAMPLE_REQ) n_req++;
            if (oAUD_BCK) n_bck++;
            if (oAUD_LRCK) n_lrck++;
        end
        check("dis_req_cnt", 32'(n_req), 32'd0);
        check("dis_bck_cnt", 32'(n_bck), 32'd0);
        check("dis_lrck_cnt", 32'(n_lrck), 32'd0);
        check("dis_lsnd", 32'(oLSOUND), 32'h1111);
        check("dis_lvl", 32'(oFIFO_LEVEL), 32'd1);
        iENABLE = 1'b1;
        go_to(1203); check("re_bck1203", 32'(oAUD_BCK), 32'd0);
        go_to(1204); check("re_bck1204", 32'(oAUD_BCK), 32'd1);
        go_to(1711); check("re_req1711", 32'(oSAMPLE_REQ), 32'd0);
                     check("re_lsnd1711", 32'(oLSOUND), 32'h1111);
        go_to(1712); check("re_req1712", 32'(oSAMPLE_REQ), 32'd1);
                     check("re_lsnd1712", 32'(oLSOUND), 32'h3333);
                     check("re_rsnd1712", 32'(oRSOUND), 32'h4444);
                     check("re_lvl1712", 32'(oFIFO_LEVEL), 32'd0);
                     check("re_und1712", 32'(oUNDERRUN_CNT), 32'd0);

        // Async reset mid-frame with data held
        go_to(1720);
        push(16'hBEEF, 16'hCAFE);
        go_to(2000);
        #2 iRST_N = 1'b0;
        #1;
        check("arst2_lsnd", 32'(oLSOUND), 32'd0);
        check("arst2_lvl", 32'(oFIFO_LEVEL), 32'd0);
        check("arst2_rdy", 32'(oSAMPLE_READY), 32'd1);
        check("arst2_bck", 32'(oAUD_BCK), 32'd0);
        check("arst2_lrck", 32'(oAUD_LRCK), 32'd0);
        @(negedge mCLK);
        iRST_N = 1'b1;

        // Underrun saturation on the 64-cycle-frame instance
        f_rst_n = 1'b1;
        cyc     = 0;
        go_to(63);    check("f_req63", 32'(f_req), 32'd0);
        go_to(64);    check("f_req64", 32'(f_req), 32'd1);
                      check("f_und64", 32'(f_und), 32'd1);
        go_to(16256); check("f_und254", 32'(f_und), 32'd254);
        go_to(16320); check("f_und255", 32'(f_und), 32'd255);
        go_to(19201); check("f_und300", 32'(f_und), 32'd255);
        #2 f_rst_n = 1'b0;
        #1;
        check("f_arst_und", 32'(f_und), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
